gpu_muldiv_unit: RTL and testbench
==================================

GPU_MULDIV_UNIT -- requirements
Module: gpu_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO register width.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1: the operation request.
REQ-005 SHALL have port op, input, muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI or MTLO, as decoded by the controller.
REQ-006 SHALL have port a, input, WIDTH: rs (multiplicand or dividend), and the MTHI/MTLO source.
REQ-007 SHALL have port b, input, WIDTH: rt (multiplier or divisor).
REQ-008 SHALL have port ready, output, 1: the unit accepts start this cycle.
REQ-009 SHALL have port done, output, 1: a one-cycle pulse when a new MULT/DIV result is visible on hi/lo.
REQ-010 SHALL have port hi, output, WIDTH: the HI register, read by MFHI.
REQ-011 SHALL have port lo, output, WIDTH: the LO register, read by MFLO.
REQ-012 SHALL have port div_by_zero, output, 1: set for the last completed divide when b was 0, cleared by any other completed op.

Function
REQ-013 SHALL have the states IDLE, RUN and FIX; ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept a request only when start and ready are both 1; start while not ready SHALL be ignored, not queued.
REQ-015 SHALL latch a, b and op at acceptance; later input changes SHALL have no effect.
REQ-016 On accepted MTHI/MTLO, SHALL write a into hi/lo on the same edge, stay in IDLE and not pulse done.
REQ-017 On accepted MULT/MULTU/DIV/DIVU, SHALL go IDLE->RUN with an iteration counter of 0.
REQ-018 Signed ops SHALL convert operands to magnitude at acceptance and record the result signs.
REQ-019 MULT(U) SHALL use shift-add, one bit per cycle, into a 2*WIDTH accumulator.
REQ-020 DIV(U) SHALL use restoring division, one quotient bit per cycle.
REQ-021 RUN SHALL last exactly WIDTH cycles, then go to FIX.
REQ-022 FIX SHALL last one cycle, apply sign correction, write hi/lo and go to IDLE.
REQ-023 Sign correction SHALL be: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-024 Multiply results SHALL be hi = upper WIDTH bits and lo = lower WIDTH bits.
REQ-025 Divide results SHALL be lo = quotient and hi = remainder.
REQ-026 Divide by zero SHALL give lo = all ones, hi = dividend and div_by_zero = 1, with the same latency as any divide.
REQ-027 Signed overflow (most negative / -1) SHALL give lo = most negative and hi = 0, with no flag.
REQ-028 done SHALL be 1 exactly WIDTH+2 cycles after the accepting edge, in the IDLE cycle where hi/lo first show the result.
REQ-029 A start in the done cycle SHALL be accepted (back-to-back).
REQ-030 hi/lo SHALL hold their previous values throughout RUN and FIX.

Reset
REQ-031 On reset: state = IDLE, hi = 0, lo = 0, done = 0, div_by_zero = 0, counter = 0, ready = 1 in the following cycle.
REQ-032 Reset mid-operation SHALL abandon the operation with no done pulse and no hi/lo update.
REQ-033 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-034 The macro GPU_MULDIV_SIGNED_EN SHALL compile in signed support.
REQ-035 With GPU_MULDIV_SIGNED_EN defined, the unit SHALL behave as in REQ-018 and REQ-023.
REQ-036 Without GPU_MULDIV_SIGNED_EN, MULT SHALL execute as MULTU and DIV as DIVU, with no sign logic synthesized.
REQ-037 Without GPU_MULDIV_SIGNED_EN, REQ-027 SHALL not apply.

Structure
REQ-038 muldiv_op_t (enum) and the state enum SHALL be defined in the shared package gpu_pkg, alongside the controller's opcode constants.
REQ-039 The iteration count SHALL be derived as $clog2(WIDTH) bits from WIDTH.
REQ-040 SHALL be a single module with no sub-module; multiply and divide share the accumulator and counter.

Verification (WIDTH=32)
REQ-041 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after acceptance.
REQ-042 MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-043 DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1; a following MULTU 2*3 -> lo=6, div_by_zero=0.
REQ-044 MTHI a=0x1234 while in RUN -> ignored; the same MTHI in IDLE -> hi=0x1234 next cycle, no done.
REQ-045 reset asserted at cycle 10 of a DIVU -> hi=lo=0, no done pulse, ready=1 in the cycle after reset.
REQ-046 start a second MULTU in the done cycle -> accepted, second done 34 cycles later.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared controller opcodes and mul/div unit types.
package gpu_pkg;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV = 6'h1a;
  localparam logic [5:0] F_DIVU = 6'h1b;
  typedef enum logic [2:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} muldiv_state_t;
  function automatic muldiv_op_t funct_to_op(input logic [5:0] f);
    return f == F_MULT ? OP_MULT : f == F_MULTU ? OP_MULTU : f == F_DIV ? OP_DIV :
           f == F_DIVU ? OP_DIVU : f == F_MTHI ? OP_MTHI : OP_MTLO;
  endfunction
endpackage

// File: rtl/gpu_muldiv_unit.sv
// gpu_muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO registers.
// GPU_MULDIV_SIGNED_EN compiles in signed MULT/DIV; otherwise they execute as MULTU/DIVU.
module gpu_muldiv_unit
  import gpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  muldiv_state_t state;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0] dv, ma, mb, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0] msum, rsh, rdiff;
  logic [CW-1:0] cnt;
  logic is_div, bz, acc_div;
`ifdef GPU_MULDIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
`endif
  assign ready = state == IDLE;
  always_comb begin
    acc_div = op == OP_DIV || op == OP_DIVU;
`ifdef GPU_MULDIV_SIGNED_EN
    sa = (op == OP_MULT || op == OP_DIV) && a[WIDTH-1];
    sb = (op == OP_MULT || op == OP_DIV) && b[WIDTH-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
    ma = a;
    mb = b;
    prod = acc;
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
`endif
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv} : '0);
    rsh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rdiff = rsh - {1'b0, dv};
    step = is_div ? (rdiff[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                  : {msum, acc[WIDTH-1:1]};
    fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? (bz ? '1 : quo) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      acc <= '0;
      dv <= '0;
      is_div <= 1'b0;
      bz <= 1'b0;
`ifdef GPU_MULDIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op == OP_MTHI) begin
            hi <= a;
            div_by_zero <= 1'b0;
          end else if (op == OP_MTLO) begin
            lo <= a;
            div_by_zero <= 1'b0;
          end else begin
            state <= RUN;
            cnt <= '0;
            acc <= {{WIDTH{1'b0}}, ma};
            dv <= mb;
            is_div <= acc_div;
            bz <= b == '0;
`ifdef GPU_MULDIV_SIGNED_EN
            neg_q <= sa ^ sb;
            neg_r <= sa;
`endif
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
          div_by_zero <= is_div && bz;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_muldiv_unit.sv
// tb_gpu_muldiv_unit: directed self-checking bench for gpu_muldiv_unit at WIDTH=32.
module tb_gpu_muldiv_unit;
  import gpu_pkg::*;
  logic clk = 0, reset = 0, start = 0;
  muldiv_op_t op = OP_MULTU;
  logic [31:0] a = 0, b = 0;
  logic ready, done, div_by_zero;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  gpu_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y, output int lat);
    start = 1; op = o; a = x; b = y;
    step_clk();
    start = 0; a = 32'hdead_beef; b = 32'h0bad_f00d;
    lat = 1;
    while (!done && lat < 100) begin
      step_clk();
      lat++;
    end
  endtask
  task automatic test_reset();
    reset = 1; start = 1; op = OP_MTHI; a = 32'h5555_aaaa;
    step_clk();
    start = 0; reset = 0;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got hi=%h lo=%h exp 0/0", hi, lo); end
    total++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%b dbz=%b exp 0/0", done, div_by_zero); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", ready); end
  endtask
  task automatic test_multu_max();
    int lat;
    issue(OP_MULTU, 32'hffff_ffff, 32'hffff_ffff, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL multu_latency got %0d exp 34", lat); end
    total++; if (hi !== 32'hffff_fffe || lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_max got %h_%h exp fffffffe_00000001", hi, lo); end
    step_clk();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got %b exp 0", done); end
  endtask
  task automatic test_signed();
    int lat;
    logic [31:0] eh, el;
`ifdef GPU_MULDIV_SIGNED_EN
    eh = 32'hffff_ffff; el = 32'hffff_ffeb;
`else
    eh = 32'h0000_0006; el = 32'hffff_ffeb;
`endif
    issue(OP_MULT, 32'hffff_fffd, 32'd7, lat);
    total++; if (hi !== eh || lo !== el) begin bad++; $display("FAIL mult_neg got %h_%h exp %h_%h", hi, lo, eh, el); end
`ifdef GPU_MULDIV_SIGNED_EN
    eh = 32'hffff_ffff; el = 32'hffff_fffd;
`else
    eh = 32'h0000_0001; el = 32'h7fff_fffc;
`endif
    issue(OP_DIV, 32'hffff_fff9, 32'd2, lat);
    total++; if (hi !== eh || lo !== el) begin bad++; $display("FAIL div_neg got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, eh, el); end
`ifdef GPU_MULDIV_SIGNED_EN
    eh = 32'h0; el = 32'h8000_0000;
`else
    eh = 32'h8000_0000; el = 32'h0;
`endif
    issue(OP_DIV, 32'h8000_0000, 32'hffff_ffff, lat);
    total++; if (hi !== eh || lo !== el || div_by_zero !== 1'b0) begin bad++; $display("FAIL div_ovf got hi=%h lo=%h dbz=%b exp hi=%h lo=%h dbz=0", hi, lo, div_by_zero, eh, el); end
    issue(OP_DIV, 32'hffff_fffb, 32'd0, lat);
    total++; if (hi !== 32'hffff_fffb || lo !== 32'hffff_ffff || div_by_zero !== 1'b1) begin bad++; $display("FAIL div_zero_neg got hi=%h lo=%h dbz=%b exp fffffffb/ffffffff/1", hi, lo, div_by_zero); end
  endtask
  task automatic test_div_zero();
    int lat;
    issue(OP_DIVU, 32'd5, 32'd0, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL divz_latency got %0d exp 34", lat); end
    total++; if (hi !== 32'd5 || lo !== 32'hffff_ffff || div_by_zero !== 1'b1) begin bad++; $display("FAIL divu_zero got hi=%h lo=%h dbz=%b exp 5/ffffffff/1", hi, lo, div_by_zero); end
    issue(OP_MULTU, 32'd2, 32'd3, lat);
    total++; if (hi !== 32'd0 || lo !== 32'd6 || div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got hi=%h lo=%h dbz=%b exp 0/6/0", hi, lo, div_by_zero); end
  endtask
  task automatic test_mthi();
    int lat;
    start = 1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    step_clk();
    start = 0;
    step_clk(); step_clk();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL run_ready got %b exp 0", ready); end
    start = 1; op = OP_MTHI; a = 32'h1234;
    step_clk();
    start = 0; a = 32'h0;
    lat = 4;
    while (!done && lat < 100) begin
      step_clk();
      lat++;
    end
    total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got %0d exp 34", lat); end
    total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL mthi_in_run got hi=%h lo=%h exp 2/e", hi, lo); end
    step_clk();
    start = 1; op = OP_MTHI; a = 32'h1234;
    step_clk();
    start = 0;
    total++; if (hi !== 32'h1234 || lo !== 32'd14 || done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL mthi_idle got hi=%h lo=%h done=%b ready=%b exp 1234/e/0/1", hi, lo, done, ready); end
    start = 1; op = OP_MTLO; a = 32'h00ab_cdef;
    step_clk();
    start = 0;
    total++; if (hi !== 32'h1234 || lo !== 32'h00ab_cdef || done !== 1'b0) begin bad++; $display("FAIL mtlo_idle got hi=%h lo=%h done=%b exp 1234/abcdef/0", hi, lo, done); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    start = 1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    step_clk();
    start = 0;
    repeat (9) step_clk();
    reset = 1;
    step_clk();
    reset = 0;
    total++; if (hi !== 32'h0 || lo !== 32'h0 || ready !== 1'b1) begin bad++; $display("FAIL reset_mid got hi=%h lo=%h ready=%b exp 0/0/1", hi, lo, ready); end
    repeat (40) begin
      if (done) seen++;
      step_clk();
    end
    total++; if (seen !== 0 || hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_abandon got dones=%0d hi=%h lo=%h exp 0/0/0", seen, hi, lo); end
  endtask
  task automatic test_back_to_back();
    int lat;
    issue(OP_MULTU, 32'd3, 32'd5, lat);
    total++; if (lo !== 32'd15 || ready !== 1'b1) begin bad++; $display("FAIL b2b_first got lo=%h ready=%b exp f/1", lo, ready); end
    issue(OP_MULTU, 32'd4, 32'd6, lat);
    total++; if (lat !== 34 || lo !== 32'd24 || hi !== 32'd0) begin bad++; $display("FAIL b2b_second got lat=%0d hi=%h lo=%h exp 34/0/18", lat, hi, lo); end
  endtask
  initial begin
    step_clk();
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_mthi();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
